// File: rtl/gost_key_sched.sv
// ---------------------------------------------------------------------------
// gost_key_sched
//
// Round sequencer and key scheduler for the GOST 28147-89 round datapath.
// The module latches a 256-bit key and the direction on a start pulse. It then
// steps a round counter through the block operation, advancing one round per
// cycle in which the datapath is not stalled. Each round it presents the
// matching 32-bit subkey to the modulo-2^32 adder's key operand (iB).
//
// Ports:
//   iclk      in   1    clock
//   irst      in   1    asynchronous active-high reset
//   istart    in   1    start pulse, accepted only while idle
//   iencrypt  in   1    1 = encrypt subkey order, 0 = decrypt order
//   ikey      in   256  key, K0 = ikey[31:0] ... K7 = ikey[255:224]
//   imac      in   1    (GOST_MAC_MODE_EN only) 1 = 16-round MAC schedule
//   istall    in   1    hold the current round
//   okey      out  32   subkey for the current round
//   oround    out  5    current round index
//   ovalid    out  1    okey/oround valid (RUN state)
//   olast     out  1    current round is the final round
//   obusy     out  1    sequencer not idle
//   odone     out  1    one-cycle pulse after the final round retires
//
// Optional feature macro: GOST_MAC_MODE_EN
//   When this macro is defined, the imac port is added. With imac=1 the block
//   runs 16 rounds with subkey index r mod 8 and ignores iencrypt.
//   Without the macro, every operation runs 32 rounds.
// ---------------------------------------------------------------------------
module gost_key_sched #(
    parameter int KEY_WORDS = 8,
    parameter int ROUNDS    = 32,
    parameter int RND_W     = 5
) (
    input  logic                    iclk,
    input  logic                    irst,
    input  logic                    istart,
    input  logic                    iencrypt,
    input  logic [KEY_WORDS*32-1:0] ikey,
`ifdef GOST_MAC_MODE_EN
    input  logic                    imac,
`endif
    input  logic                    istall,
    output logic [31:0]             okey,
    output logic [RND_W-1:0]        oround,
    output logic                    ovalid,
    output logic                    olast,
    output logic                    obusy,
    output logic                    odone
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    logic [KEY_WORDS*32-1:0]   r_key;
    logic                      r_enc;
    logic                      r_mac;
    logic [RND_W-1:0]          r_round;
    logic [31:0]               r_okey;

    logic [31:0]               w_key_words [KEY_WORDS];
    logic [RND_W-1:0]          w_next_round;
    logic [RND_W-1:0]          w_last_round;
    logic [2:0]                w_next_idx;
    logic [31:0]               w_next_key;

    // Split the latched key into its eight 32-bit subkeys.
    genvar gi;
    generate
        for (gi = 0; gi < KEY_WORDS; gi++) begin : g_words
            assign w_key_words[gi] = r_key[gi*32 +: 32];
        end
    endgenerate

    // Subkey index for a round. For the descending parts of the schedule,
    // 31-r and 7-(r mod 8) are both the bitwise inverse of the low three bits.
    function automatic logic [2:0] subkey_idx(
        input logic [RND_W-1:0] r,
        input logic             enc,
        input logic             mac
    );
        logic [2:0] lo;
        lo = r[2:0];
        if (mac)
            subkey_idx = lo;
        else if (enc)
            subkey_idx = (r < RND_W'(24)) ? lo : ~lo;
        else
            subkey_idx = (r < RND_W'(8)) ? lo : ~lo;
    endfunction

    assign w_next_round = r_round + RND_W'(1);
    assign w_last_round = r_mac ? RND_W'(ROUNDS/2 - 1) : RND_W'(ROUNDS - 1);
    assign w_next_idx   = subkey_idx(w_next_round, r_enc, r_mac);
    assign w_next_key   = w_key_words[w_next_idx];

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_state <= S_IDLE;
            r_key   <= '0;
            r_enc   <= 1'b0;
            r_mac   <= 1'b0;
            r_round <= '0;
            r_okey  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (istart) begin
                        r_key   <= ikey;
                        r_enc   <= iencrypt;
`ifdef GOST_MAC_MODE_EN
                        r_mac   <= imac;
`else
                        r_mac   <= 1'b0;
`endif
                        r_round <= '0;
                        // Round 0 uses K0 in every schedule. The key is taken
                        // straight from the input because r_key is not loaded yet.
                        r_okey  <= ikey[31:0];
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!istall) begin
                        if (r_round == w_last_round) begin
                            // The counter does not wrap. okey and oround keep
                            // the final round's values through DONE.
                            r_state <= S_DONE;
                        end else begin
                            r_round <= w_next_round;
                            r_okey  <= w_next_key;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign okey   = r_okey;
    assign oround = r_round;
    assign ovalid = (r_state == S_RUN);
    assign obusy  = (r_state != S_IDLE);
    assign odone  = (r_state == S_DONE);
    assign olast  = ovalid && (r_round == w_last_round);

endmodule

// File: tb/tb_gost_key_sched.sv
module tb_gost_key_sched;

    logic         iclk;
    logic         irst;
    logic         istart;
    logic         iencrypt;
    logic [255:0] ikey;
    logic         imac;
    logic         istall;
    logic [31:0]  okey;
    logic [4:0]   oround;
    logic         ovalid;
    logic         olast;
    logic         obusy;
    logic         odone;

    int n_chk = 0;
    int n_err = 0;

    gost_key_sched dut (
        .iclk     (iclk),
        .irst     (irst),
        .istart   (istart),
        .iencrypt (iencrypt),
        .ikey     (ikey),
`ifdef GOST_MAC_MODE_EN
        .imac     (imac),
`endif
        .istall   (istall),
        .okey     (okey),
        .oround   (oround),
        .ovalid   (ovalid),
        .olast    (olast),
        .obusy    (obusy),
        .odone    (odone)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference schedule: which key word K[j] is used in round r.
    function automatic int exp_idx(int r, bit enc, bit mac);
        if (mac) return r % 8;
        if (enc) return (r < 24) ? (r % 8) : (31 - r);
        return (r < 8) ? r : (7 - (r % 8));
    endfunction

    task automatic check_all_zero(input string name);
        check({name, ":rst_okey"},   64'(okey),   64'h0);
        check({name, ":rst_oround"}, 64'(oround), 64'h0);
        check({name, ":rst_ovalid"}, 64'(ovalid), 64'h0);
        check({name, ":rst_olast"},  64'(olast),  64'h0);
        check({name, ":rst_obusy"},  64'(obusy),  64'h0);
        check({name, ":rst_odone"},  64'(odone),  64'h0);
    endtask

    // Run one block operation. The task is entered and left at a negedge.
    // stall_at/restart_at/abort_at < 0 disables that event.
    task automatic run_op(input string name, input logic [255:0] key, input bit enc,
                          input bit mac, input int stall_at, input int stall_n,
                          input int restart_at, input int abort_at);
        int  r;
        int  stalls;
        int  cyc;
        int  last;
        bit  restarted;
        bit  stalled;
        logic [31:0] kw;
        last      = mac ? 15 : 31;
        r         = 0;
        stalls    = 0;
        restarted = 0;
        ikey      = key;
        iencrypt  = enc;
        imac      = mac;
        istall    = 1'b0;
        istart    = 1'b1;
        @(posedge iclk);
        @(negedge iclk);
        istart = 1'b0;
        cyc    = 1;
        for (int k = 0; k < 100; k++) begin
            kw = key[exp_idx(r, enc, mac)*32 +: 32];
            check({name, ":ovalid"}, 64'(ovalid), 64'h1);
            check({name, ":oround"}, 64'(oround), 64'(r));
            check({name, ":okey"},   64'(okey),   64'(kw));
            check({name, ":olast"},  64'(olast),  64'(r == last));
            check({name, ":obusy"},  64'(obusy),  64'h1);
            check({name, ":odone"},  64'(odone),  64'h0);
            if (r == abort_at) begin
                #2 irst = 1'b1;
                #1 check_all_zero(name);
                istall = 1'b0;
                #1 irst = 1'b0;
                for (int q = 0; q < 3; q++) begin
                    @(negedge iclk);
                    check({name, ":abort_ovalid"}, 64'(ovalid), 64'h0);
                    check({name, ":abort_obusy"},  64'(obusy),  64'h0);
                    check({name, ":abort_odone"},  64'(odone),  64'h0);
                end
                $display("op %s: aborted at round %0d", name, r);
                return;
            end
            istart = 1'b0;
            if (r == restart_at && !restarted) begin
                istart    = 1'b1;
                ikey      = ~key;
                iencrypt  = ~enc;
                imac      = ~mac;
                restarted = 1;
            end
            stalled = (r == stall_at) && (stalls < stall_n);
            if (stalled) stalls++;
            istall = stalled;
            @(posedge iclk);
            @(negedge iclk);
            cyc++;
            if (!stalled) begin
                if (r == last) break;
                r++;
            end
        end
        istart = 1'b0;
        istall = 1'b0;
        check({name, ":done_odone"},  64'(odone),  64'h1);
        check({name, ":done_ovalid"}, 64'(ovalid), 64'h0);
        check({name, ":done_olast"},  64'(olast),  64'h0);
        check({name, ":done_obusy"},  64'(obusy),  64'h1);
        check({name, ":done_cycle"},  64'(cyc),    64'(last + 2 + stalls));
        @(posedge iclk);
        @(negedge iclk);
        check({name, ":idle_odone"},  64'(odone),  64'h0);
        check({name, ":idle_obusy"},  64'(obusy),  64'h0);
        check({name, ":idle_ovalid"}, 64'(ovalid), 64'h0);
        $display("op %s: enc=%0d mac=%0d stalls=%0d done at cycle %0d", name, enc, mac, stalls, cyc);
    endtask

    logic [255:0] dkey;
    logic [255:0] rkey;

    initial begin
        irst     = 1'b1;
        istart   = 1'b0;
        iencrypt = 1'b0;
        ikey     = '0;
        imac     = 1'b0;
        istall   = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge iclk);
        #1 irst = 1'b0;
        for (int q = 0; q < 3; q++) begin
            @(negedge iclk);
            check("idle_ovalid", 64'(ovalid), 64'h0);
            check("idle_obusy",  64'(obusy),  64'h0);
        end
        $display("op reset: idle after release");

        for (int n = 0; n < 8; n++) dkey[n*32 +: 32] = 32'h1111_1111 * (n + 1);

        run_op("enc",     dkey, 1'b1, 1'b0, -1, 0, -1, -1);
        run_op("dec",     dkey, 1'b0, 1'b0, -1, 0, -1, -1);
        run_op("stall",   dkey, 1'b1, 1'b0,  5, 3, -1, -1);
        run_op("restart", dkey, 1'b1, 1'b0, -1, 0, 10, -1);
        run_op("abort",   dkey, 1'b1, 1'b0, -1, 0, -1, 20);
        run_op("after",   dkey, 1'b1, 1'b0, -1, 0, -1, -1);

        for (int t = 0; t < 6; t++) begin
            for (int n = 0; n < 8; n++) rkey[n*32 +: 32] = $urandom;
            run_op($sformatf("rnd%0d", t), rkey, 1'($urandom_range(0, 1)), 1'b0,
                   $urandom_range(0, 31), $urandom_range(0, 4),
                   $urandom_range(0, 31), -1);
        end

`ifdef GOST_MAC_MODE_EN
        run_op("mac",       dkey, 1'b0, 1'b1, -1, 0, -1, -1);
        run_op("mac_stall", dkey, 1'b1, 1'b1, 15, 2,  3, -1);
        run_op("mac_off",   dkey, 1'b1, 1'b0, -1, 0, -1, -1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
